// File: rtl/fifo_pkt_reader.sv
// fifo_pkt_reader: pops a show-ahead FIFO, parses length-prefixed frames and
// presents them on a valid/ready stream through a 2-entry skid buffer.
module fifo_pkt_reader #(
    parameter int DATA_BIT = 16,
    parameter int LEN_BIT  = 8,
    parameter int CNT_BIT  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_BIT-1:0] fifo_rd_data,
    input  logic                fifo_empty,
    output logic                fifo_rd_en,
    input  logic                flush,
    output logic [DATA_BIT-1:0] m_data,
    output logic                m_sop,
    output logic                m_eop,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                pkt_busy,
    output logic [CNT_BIT-1:0]  pkt_cnt,
    output logic                len_err
);
    typedef enum logic {HDR, PAY} state_t;

    state_t              state;
    logic [LEN_BIT-1:0]  rem;
    logic [LEN_BIT-1:0]  len;
    logic [1:0]          count;
    logic [1:0]          c_after;
    logic [DATA_BIT-1:0] d0, d1;
    logic                s0, s1, e0, e1;
    logic                xfer, tag_eop;

    // Registered count only, so the pop strobe never depends on m_ready.
    assign fifo_rd_en = rst_n && !fifo_empty && (count < 2'd2) && !flush;
    assign xfer       = m_valid && m_ready;
    assign c_after    = count - {1'b0, xfer};
    assign len        = fifo_rd_data[LEN_BIT-1:0];
    assign tag_eop    = (state == HDR) ? (len == '0) : (rem == LEN_BIT'(1));
    assign m_valid    = count != 2'd0;
    assign m_data     = d0;
    assign m_sop      = s0;
    assign m_eop      = e0;
    assign pkt_busy   = state == PAY;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= HDR;
            rem     <= '0;
            count   <= 2'd0;
            d0      <= '0;
            d1      <= '0;
            s0      <= 1'b0;
            s1      <= 1'b0;
            e0      <= 1'b0;
            e1      <= 1'b0;
            pkt_cnt <= '0;
            len_err <= 1'b0;
        end else begin
            len_err <= 1'b0;
            if (flush) begin
                count <= 2'd0;
                state <= HDR;
                rem   <= '0;
            end else begin
                count <= c_after + {1'b0, fifo_rd_en};
                if (xfer && count == 2'd2)
                    {d0, s0, e0} <= {d1, s1, e1};
                // A new word lands in the first slot left free after this cycle's transfer.
                if (fifo_rd_en) begin
                    if (c_after == 2'd0)
                        {d0, s0, e0} <= {fifo_rd_data, state == HDR, tag_eop};
                    else
                        {d1, s1, e1} <= {fifo_rd_data, state == HDR, tag_eop};
                    if (state == HDR) begin
                        if (len == '0) begin
                            len_err <= 1'b1;
                            pkt_cnt <= pkt_cnt + CNT_BIT'(1);
                        end else begin
                            rem   <= len;
                            state <= PAY;
                        end
                    end else begin
                        rem <= rem - LEN_BIT'(1);
                        if (rem == LEN_BIT'(1)) begin
                            pkt_cnt <= pkt_cnt + CNT_BIT'(1);
                            state   <= HDR;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_fifo_pkt_reader.sv
// tb_fifo_pkt_reader: directed tests of fifo_pkt_reader against a simple
// show-ahead FIFO model, built with a 4-bit packet counter to reach the wrap.
module tb_fifo_pkt_reader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] fifo_rd_data;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        flush = 1'b0;
    logic [15:0] m_data;
    logic        m_sop, m_eop, m_valid;
    logic        m_ready = 1'b0;
    logic        pkt_busy;
    logic [3:0]  pkt_cnt;
    logic        len_err;

    logic [15:0] mem [0:255];
    int          head = 0, tail = 0, pops = 0;
    logic        hold_empty = 1'b0, clr = 1'b0;
    logic [17:0] got [$];
    int          n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    fifo_pkt_reader #(.DATA_BIT(16), .LEN_BIT(8), .CNT_BIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .flush(flush), .m_data(m_data), .m_sop(m_sop),
        .m_eop(m_eop), .m_valid(m_valid), .m_ready(m_ready), .pkt_busy(pkt_busy),
        .pkt_cnt(pkt_cnt), .len_err(len_err)
    );

    assign fifo_empty   = (head == tail) || hold_empty;
    assign fifo_rd_data = mem[head[7:0]];

    always @(posedge clk) begin
        if (clr) head <= tail;
        else if (fifo_rd_en) begin
            head <= head + 1;
            pops <= pops + 1;
        end
        if (rst_n && !flush && m_valid && m_ready) got.push_back({m_sop, m_eop, m_data});
    end

    task automatic put(input logic [15:0] w);
        mem[tail[7:0]] = w;
        tail = tail + 1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        put(16'h0003);
        repeat (2) @(negedge clk);
        #1;
        n_chk++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
        n_chk++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", m_valid); end
        n_chk++; if ({m_data, m_sop, m_eop} !== 18'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {m_data, m_sop, m_eop}); end
        n_chk++; if ({pkt_busy, len_err, pkt_cnt} !== 6'h0) begin n_fail++; $display("FAIL reset_status: got %h want 0", {pkt_busy, len_err, pkt_cnt}); end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [5:0]  ex_rd   = 6'b001111;
        logic [5:0]  ex_v    = 6'b011110;
        logic [5:0]  ex_busy = 6'b001110;
        logic [17:0] ex_w [6] = '{18'h0, {2'b10, 16'h0003}, {2'b00, 16'h00A1},
                                  {2'b00, 16'h00B2}, {2'b01, 16'h00C3}, 18'h0};
        m_ready = 1'b1;
        put(16'h0003); put(16'h00A1); put(16'h00B2); put(16'h00C3);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            n_chk++; if (fifo_rd_en !== ex_rd[i]) begin n_fail++; $display("FAIL basic_rd_en[%0d]: got %b want %b", i, fifo_rd_en, ex_rd[i]); end
            n_chk++; if (m_valid !== ex_v[i]) begin n_fail++; $display("FAIL basic_valid[%0d]: got %b want %b", i, m_valid, ex_v[i]); end
            n_chk++; if (pkt_busy !== ex_busy[i]) begin n_fail++; $display("FAIL basic_busy[%0d]: got %b want %b", i, pkt_busy, ex_busy[i]); end
            if (ex_v[i]) begin
                n_chk++; if ({m_sop, m_eop, m_data} !== ex_w[i]) begin n_fail++; $display("FAIL basic_word[%0d]: got %h want %h", i, {m_sop, m_eop, m_data}, ex_w[i]); end
            end
        end
        n_chk++; if (pkt_cnt !== 4'd1) begin n_fail++; $display("FAIL basic_cnt: got %0d want 1", pkt_cnt); end
    endtask

    task automatic test_backpressure;
        int          gbase = got.size();
        int          p0 = pops;
        logic [17:0] ex_w [4] = '{{2'b10, 16'h0003}, {2'b00, 16'h00D1}, {2'b00, 16'h00D2}, {2'b01, 16'h00D3}};
        m_ready = 1'b0;
        put(16'h0003); put(16'h00D1); put(16'h00D2); put(16'h00D3);
        repeat (4) @(negedge clk);
        #1;
        n_chk++; if (pops - p0 !== 2) begin n_fail++; $display("FAIL bp_pops: got %0d want 2", pops - p0); end
        n_chk++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL bp_rd_en: got %b want 0", fifo_rd_en); end
        n_chk++; if ({m_valid, m_sop, m_eop, m_data} !== {3'b110, 16'h0003}) begin n_fail++; $display("FAIL bp_hold: got %h want %h", {m_valid, m_sop, m_eop, m_data}, {3'b110, 16'h0003}); end
        m_ready = 1'b1;
        for (int k = 0; k < 20 && got.size() < gbase + 4; k++) @(negedge clk);
        @(negedge clk);
        n_chk++; if (got.size() !== gbase + 4) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", got.size() - gbase, 4); end
        for (int k = 0; k < 4; k++) begin
            n_chk++; if (got[gbase + k] !== ex_w[k]) begin n_fail++; $display("FAIL bp_word[%0d]: got %h want %h", k, got[gbase + k], ex_w[k]); end
        end
        n_chk++; if (pkt_cnt !== 4'd2) begin n_fail++; $display("FAIL bp_cnt: got %0d want 2", pkt_cnt); end
    endtask

    task automatic test_zero_len;
        m_ready = 1'b1;
        put(16'h0000); put(16'h0001); put(16'h00D4);
        @(negedge clk); #1;
        n_chk++; if ({m_valid, m_sop, m_eop, m_data} !== {3'b111, 16'h0000}) begin n_fail++; $display("FAIL zl_hdr0: got %h want %h", {m_valid, m_sop, m_eop, m_data}, {3'b111, 16'h0000}); end
        n_chk++; if (len_err !== 1'b1) begin n_fail++; $display("FAIL zl_err_pulse: got %b want 1", len_err); end
        @(negedge clk); #1;
        n_chk++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL zl_err_clear: got %b want 0", len_err); end
        n_chk++; if ({m_valid, m_sop, m_eop, m_data} !== {3'b110, 16'h0001}) begin n_fail++; $display("FAIL zl_hdr1: got %h want %h", {m_valid, m_sop, m_eop, m_data}, {3'b110, 16'h0001}); end
        @(negedge clk); #1;
        n_chk++; if ({m_valid, m_sop, m_eop, m_data} !== {3'b101, 16'h00D4}) begin n_fail++; $display("FAIL zl_pay: got %h want %h", {m_valid, m_sop, m_eop, m_data}, {3'b101, 16'h00D4}); end
        n_chk++; if (pkt_cnt !== 4'd4) begin n_fail++; $display("FAIL zl_cnt: got %0d want 4", pkt_cnt); end
        @(negedge clk);
    endtask

    task automatic test_empty_toggle;
        int gbase = got.size();
        int p0 = pops;
        m_ready = 1'b1;
        put(16'h0005);
        for (int k = 1; k <= 5; k++) put(16'h0050 + 16'(k));
        for (int i = 0; i < 20; i++) begin
            hold_empty = i[0];
            #1;
            if (hold_empty) begin
                n_chk++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL et_pop_when_empty[%0d]: got %b want 0", i, fifo_rd_en); end
            end
            @(negedge clk);
        end
        hold_empty = 1'b0;
        @(negedge clk);
        n_chk++; if (pops - p0 !== 6) begin n_fail++; $display("FAIL et_pops: got %0d want 6", pops - p0); end
        n_chk++; if (got.size() !== gbase + 6) begin n_fail++; $display("FAIL et_count: got %0d want 6", got.size() - gbase); end
        for (int k = 0; k < 6; k++) begin
            logic [17:0] ew;
            ew = (k == 0) ? {2'b10, 16'h0005} : {1'b0, k == 5, 16'h0050 + 16'(k)};
            n_chk++; if (got[gbase + k] !== ew) begin n_fail++; $display("FAIL et_word[%0d]: got %h want %h", k, got[gbase + k], ew); end
        end
        n_chk++; if (pkt_cnt !== 4'd5) begin n_fail++; $display("FAIL et_cnt: got %0d want 5", pkt_cnt); end
    endtask

    task automatic test_flush;
        int p0 = pops;
        m_ready = 1'b1;
        put(16'h0004); put(16'h00E1); put(16'h00E2); put(16'h00E3); put(16'h00E4);
        repeat (2) @(negedge clk);
        flush = 1'b1;
        clr = 1'b1;
        #1;
        n_chk++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL fl_rd_en: got %b want 0", fifo_rd_en); end
        @(negedge clk);
        flush = 1'b0;
        clr = 1'b0;
        #1;
        n_chk++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL fl_valid: got %b want 0", m_valid); end
        n_chk++; if (pkt_busy !== 1'b0) begin n_fail++; $display("FAIL fl_busy: got %b want 0", pkt_busy); end
        n_chk++; if (pkt_cnt !== 4'd5) begin n_fail++; $display("FAIL fl_cnt: got %0d want 5", pkt_cnt); end
        n_chk++; if (pops - p0 !== 2) begin n_fail++; $display("FAIL fl_pops: got %0d want 2", pops - p0); end
        put(16'h0000);
        @(negedge clk); #1;
        n_chk++; if ({len_err, m_sop, m_eop} !== 3'b111) begin n_fail++; $display("FAIL fl_hdr_after: got %b want 111", {len_err, m_sop, m_eop}); end
        n_chk++; if (pkt_cnt !== 4'd6) begin n_fail++; $display("FAIL fl_cnt_after: got %0d want 6", pkt_cnt); end
        @(negedge clk);
    endtask

    task automatic test_wrap;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_ready = 1'b1;
        for (int f = 0; f < 15; f++) begin put(16'h0001); put(16'h0100 + 16'(f)); end
        for (int k = 0; k < 100 && (head != tail || m_valid); k++) @(negedge clk);
        #1;
        n_chk++; if (pkt_cnt !== 4'd15) begin n_fail++; $display("FAIL wrap_15: got %0d want 15", pkt_cnt); end
        put(16'h0001); put(16'h01FF);
        for (int k = 0; k < 20 && (head != tail || m_valid); k++) @(negedge clk);
        #1;
        n_chk++; if (pkt_cnt !== 4'd0) begin n_fail++; $display("FAIL wrap_0: got %0d want 0", pkt_cnt); end
        @(negedge clk);
    endtask

    task automatic test_async_reset;
        m_ready = 1'b0;
        put(16'h0100); put(16'h0002); put(16'h00F1);
        repeat (3) @(negedge clk);
        #1;
        n_chk++; if ({pkt_busy, pkt_cnt, m_data} !== {1'b1, 4'd1, 16'h0100}) begin n_fail++; $display("FAIL ar_pre: got %h want %h", {pkt_busy, pkt_cnt, m_data}, {1'b1, 4'd1, 16'h0100}); end
        #1 rst_n = 1'b0;
        #1;
        n_chk++; if ({m_valid, m_sop, m_eop, m_data} !== 19'h0) begin n_fail++; $display("FAIL ar_stream: got %h want 0", {m_valid, m_sop, m_eop, m_data}); end
        n_chk++; if ({pkt_busy, len_err, pkt_cnt, fifo_rd_en} !== 7'h0) begin n_fail++; $display("FAIL ar_status: got %h want 0", {pkt_busy, len_err, pkt_cnt, fifo_rd_en}); end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_basic;
        test_backpressure;
        test_zero_len;
        test_empty_toggle;
        test_flush;
        test_wrap;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
